// File: rtl/fifo_sync_param_if.sv
// Bus bundle for fifo_sync_param: write/read requests, read data, status flags.
// Macro FIFO_SYNC_ERR_FLAGS_EN adds the sticky OVF/UDF error outputs.
interface fifo_sync_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             W_EN;
    logic [WIDTH-1:0] W_DI;
    logic             REN;
    logic [WIDTH-1:0] R_DO;
    logic             FULL;
    logic             EMPTY;
    logic             AFULL;
    logic             AEMPTY;
    logic [CW-1:0]    COUNT;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic             OVF;
    logic             UDF;

    modport master (
        output W_EN, W_DI, REN,
        input  R_DO, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVF, UDF
    );
    modport slave (
        input  W_EN, W_DI, REN,
        output R_DO, FULL, EMPTY, AFULL, AEMPTY, COUNT, OVF, UDF
    );
`else
    modport master (
        output W_EN, W_DI, REN,
        input  R_DO, FULL, EMPTY, AFULL, AEMPTY, COUNT
    );
    modport slave (
        input  W_EN, W_DI, REN,
        output R_DO, FULL, EMPTY, AFULL, AEMPTY, COUNT
    );
`endif
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, almost flags and optional FWFT read.
// Macro FIFO_SYNC_ERR_FLAGS_EN enables sticky overflow/underflow flags (OVF/UDF).
module fifo_sync_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_THR  = 12,
    parameter int AEMPTY_THR = 2,
    parameter int FWFT       = 0
) (
    input logic              CLK,
    input logic              RST,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_THR);
    localparam logic [CW-1:0] CNT_AE   = CW'(AEMPTY_THR);

    // Handshake: a write is taken when W_EN=1 and FULL=0, a read when REN=1 and
    // EMPTY=0, each at the rising edge; any other request is dropped with no effect.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_inc;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             wr_acc;
    logic             rd_acc;
    logic             full_q;
    logic             empty_q;
    logic             afull_q;
    logic             aempty_q;
    logic [WIDTH-1:0] rdo_q;
    logic [WIDTH-1:0] rdo_next;

    assign wr_acc   = bus.W_EN & ~full_q;
    assign rd_acc   = bus.REN & ~empty_q;
    assign rptr_inc = rptr + AW'(1);

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CW'(1);
        end
    end

    // Storage is deliberately not reset so it maps onto RAM.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wptr] <= bus.W_DI;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Output register always holds the head; load the word that becomes head.
            always_comb begin
                rdo_next = rdo_q;
                if (rd_acc) begin
                    if (count != CW'(1)) begin
                        rdo_next = mem[rptr_inc];
                    end else if (wr_acc) begin
                        rdo_next = bus.W_DI;
                    end
                end else if (empty_q && wr_acc) begin
                    rdo_next = bus.W_DI;
                end
            end
        end else begin : g_std
            always_comb begin
                rdo_next = rdo_q;
                if (rd_acc) begin
                    rdo_next = mem[rptr];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            rdo_q    <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr_inc;
            end
            count    <= count_next;
            full_q   <= (count_next == CNT_FULL);
            empty_q  <= (count_next == '0);
            afull_q  <= (count_next >= CNT_AF);
            aempty_q <= (count_next <= CNT_AE);
            rdo_q    <= rdo_next;
        end
    end

    assign bus.R_DO   = rdo_q;
    assign bus.FULL   = full_q;
    assign bus.EMPTY  = empty_q;
    assign bus.AFULL  = afull_q;
    assign bus.AEMPTY = aempty_q;
    assign bus.COUNT  = count;

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.W_EN && full_q) begin
                ovf_q <= 1'b1;
            end
            if (bus.REN && empty_q) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.OVF = ovf_q;
    assign bus.UDF = udf_q;
`endif
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Single-clock, parametrised FIFO; successor to the async circular FIFO for same-domain buffering (UART/SPI byte queues, stream decoupling).
- Adds occupancy count and programmable almost-full/almost-empty flags.
- Adds a selectable read mode: standard registered read, or first-word-fall-through (FWFT).
- Storage is an inferred RAM with binary pointers.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AFULL_THR, 12, AFULL asserted when COUNT >= AFULL_THR (1..DEPTH-1)
AEMPTY_THR, 2, AEMPTY asserted when COUNT <= AEMPTY_THR (0..DEPTH-2)
FWFT, 0, 0 = standard read (data one cycle after REN); 1 = first-word-fall-through

Ports:
CLK  in  1  single clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
W_EN  in  1  write request
W_DI  in  WIDTH  write data
REN  in  1  read request (FWFT=1: pop/acknowledge of the head word)
R_DO  out  WIDTH  read data
FULL  out  1  no free entries
EMPTY  out  1  no readable entries
AFULL  out  1  almost-full flag
AEMPTY  out  1  almost-empty flag
COUNT  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (RST=1, async): WPTR=RPTR=0, COUNT=0, EMPTY=1, FULL=0, AFULL=0, AEMPTY=1, R_DO=0. Memory contents are not cleared.
- Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally. COUNT is a separate register.
- Write accepted = W_EN & !FULL. Read accepted = REN & !EMPTY.
- Rejected requests are ignored silently: no pointer, count or data change.
- Write to full is rejected even when REN=1 in the same cycle.
- Read from empty is rejected even when W_EN=1 in the same cycle.
- COUNT update per cycle:
  - +1 on an accepted write only
  - -1 on an accepted read only
  - unchanged when both are accepted
- All flags are registered, derived from next-COUNT, and valid in the same cycle as COUNT:
  - FULL = (COUNT==DEPTH)
  - EMPTY = (COUNT==0)
  - AFULL = (COUNT>=AFULL_THR)
  - AEMPTY = (COUNT<=AEMPTY_THR)
- Standard mode (FWFT=0):
  - On an accepted read at edge N, R_DO = mem[RPTR] after edge N, i.e. valid in cycle N+1.
  - R_DO holds its last value otherwise.
  - Write-to-read latency: a word written at edge N can be read at edge N+1, earliest R_DO at N+2.
- FWFT mode (FWFT=1):
  - R_DO = mem[RPTR] continuously whenever EMPTY=0. It is the head word, with no REN needed.
  - A write into an empty FIFO at edge N: EMPTY=0 and R_DO = that word from cycle N+1.
  - REN with EMPTY=0 pops the head; the next word appears after the edge.
  - R_DO is don't-care while EMPTY=1 (implementation drives the last head value).
- Simultaneous accepted read and write at wrap-around:
  - Both pointers wrap independently.
  - Read-before-write ordering is never required, because a read of an address being written is impossible unless the FIFO is empty, and that read is rejected.
- RST asserted mid-operation: all state returns to reset values immediately. Pending data is discarded.

Optional Feature:
Macro FIFO_SYNC_ERR_FLAGS_EN.
- Defined: adds two outputs.
  - OVF (1 bit): sticky, set on W_EN&FULL.
  - UDF (1 bit): sticky, set on REN&EMPTY.
  - Both are registered, cleared only by RST, reset value 0.
- Not defined: the ports do not exist and the logic is removed. Rejected accesses remain silent.

Test Plan:
- Reset + fill (DEPTH=16, FWFT=0): write 0x10,0x01,0x91,...,0x23 (16 words) -> COUNT steps 1..16; AFULL=1 from COUNT=12; FULL=1 at 16; 17th write ignored, COUNT stays 16.
- Drain standard mode: 16 reads -> R_DO equals write order, each one cycle after REN; AEMPTY=1 at COUNT=2; EMPTY=1 at 0; 17th read leaves R_DO=0x23, COUNT=0.
- Simultaneous R/W at COUNT=5 for 40 cycles, data incrementing 0x00.. -> COUNT stays 5, pointers wrap twice, read sequence is contiguous with no gaps or duplicates.
- FWFT=1: write 0xAB into empty at edge N -> EMPTY=0 and R_DO=0xAB at N+1; write 0xCD, pulse REN -> R_DO=0xCD next cycle, COUNT=1.
- Edge cases: W_EN&REN while full -> write rejected, COUNT 16->15. W_EN&REN while empty -> read rejected, COUNT 0->1. With FIFO_SYNC_ERR_FLAGS_EN defined: OVF=1 after the full-write, UDF=1 after the empty-read, both stay set.
- Mid-operation RST pulse at COUNT=7 (asserted between edges) -> EMPTY=1, COUNT=0, R_DO=0 immediately; next write/read pair returns the new word, not stale data.
